// File: rtl/riscy_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// riscy_pkg: shared opcodes, control encodings and FSM states.
// Rev 1.0
// ------------------------------------------------------------------
package riscy_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0, ALU_SLL = 4'h1, ALU_SLT = 4'h2, ALU_SLTU = 4'h3,
      ALU_XOR  = 4'h4, ALU_SRL = 4'h5, ALU_OR  = 4'h6, ALU_AND  = 4'h7,
      ALU_SUB  = 4'h8, ALU_SRA = 4'hD
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMM = 2'b11
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
   } alu_src_b_t;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR  = 4'd6,  S_EXECI   = 4'd7,
      S_ALUWB   = 4'd8,  S_BRANCH  = 4'd9,  S_JAL    = 4'd10, S_LUIWB   = 4'd11
   } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ------------------------------------------------------------------
// branch_cond: branch-taken decision from funct3 and ALU flags {N,Z,C,V}.
// Rev 1.0
// ------------------------------------------------------------------
module branch_cond
   import riscy_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic [3:0] flags_i,
   output logic       taken_o
);

   logic n_flag, z_flag, c_flag, v_flag;

   assign {n_flag, z_flag, c_flag, v_flag} = flags_i;

   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = z_flag;
         F3_BNE:  taken_o = ~z_flag;
         F3_BLT:  taken_o = n_flag ^ v_flag;
         F3_BGE:  taken_o = ~(n_flag ^ v_flag);
         F3_BLTU: taken_o = ~c_flag;
         F3_BGEU: taken_o = c_flag;
         default: taken_o = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/control_multi.sv
`default_nettype none
// ------------------------------------------------------------------
// control_multi: multi-cycle main controller for the riscy32 core.
// Rev 1.0
// ------------------------------------------------------------------
module control_multi
   import riscy_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic [3:0] flags,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       illegal,
   output logic       retire
);

   state_t state_q, state_d;
   logic   ready;
   logic   taken;

   assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

   branch_cond u_branch_cond (
      .funct3_i (funct3),
      .flags_i  (flags),
      .taken_o  (taken)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      case (op)
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         OP_LUI:    ImmSrc = IMM_U;
         default:   ImmSrc = IMM_I;
      endcase
   end

   always_comb begin
      state_d    = S_FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUControl = ALU_ADD;
      illegal    = 1'b0;
      retire     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = ready;
            PCWrite   = ready;
            state_d   = ready ? S_DECODE : S_FETCH;
         end
         // The branch/jal target is formed here and parked in ALUOut.
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_IMM:            state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUIWB;
               default: begin
                  illegal = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            retire    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            retire   = ready;
            state_d  = ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = {funct7, funct3};
            state_d    = S_ALUWB;
         end
         // Only shifts use funct7 on OP-IMM; elsewhere that bit is immediate.
         S_EXECI: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = {(funct3 == 3'd5) ? funct7 : 1'b0, funct3};
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = ALU_SUB;
            PCWrite    = taken;
            retire     = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
            state_d = S_ALUWB;
         end
         S_LUIWB: begin
            ResultSrc = RES_IMM;
            RegWrite  = 1'b1;
            retire    = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         illegal  = 1'b0;
         retire   = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_control_multi.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_control_multi: trace-model bench for the multi-cycle controller.
// Rev 1.0
// ------------------------------------------------------------------
module tb_control_multi;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7;
   logic [3:0] flags;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, retire;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;

   control_multi #(.MEM_WAIT(1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
      .flags(flags), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .retire(retire)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, adr, memw, irw, regw;
      logic [1:0] res, sa, sb;
      logic [3:0] alu;
      logic       ill, ret;
   } exp_t;

   exp_t q[$];
   bit   rdyq[$];
   bit   scrq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   function automatic exp_t mk(input logic pcw, adr, memw, irw, regw,
                               input logic [1:0] res, sa, sb, input logic [3:0] alu,
                               input logic ill, ret);
      exp_t e;
      e = {pcw, adr, memw, irw, regw, res, sa, sb, alu, ill, ret};
      return e;
   endfunction

   function automatic logic [2:0] imm_ref(input logic [6:0] o);
      if (o == 7'b0100011) return 3'b001;
      if (o == 7'b1100011) return 3'b010;
      if (o == 7'b1101111) return 3'b011;
      if (o == 7'b0110111) return 3'b100;
      return 3'b000;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
      logic n, z, c, v;
      {n, z, c, v} = fl;
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return n ^ v;
         3'd5: return !(n ^ v);
         3'd6: return !c;
         3'd7: return c;
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input exp_t e, input bit rdy, input bit scr);
      q.push_back(e);
      rdyq.push_back(rdy);
      scrq.push_back(scr);
   endtask

   // Expected per-cycle outputs for one instruction with fw fetch stalls and mw memory stalls.
   task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic [3:0] fl, input int fw, input int mw);
      bit legal;
      legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
              (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111) ||
              (o == 7'b0110111);
      for (int i = 0; i < fw; i++) push(mk(0,0,0,0,0,2'd2,2'd0,2'd2,4'h0,0,0), 1'b0, 1'b1);
      push(mk(1,0,0,1,0,2'd2,2'd0,2'd2,4'h0,0,0), 1'b1, 1'b0);
      push(mk(0,0,0,0,0,2'd0,2'd1,2'd1,4'h0,!legal,!legal), 1'($urandom_range(0,1)), 1'b0);
      if (!legal) return;
      case (o)
         7'b0000011: begin
            push(mk(0,0,0,0,0,2'd0,2'd2,2'd1,4'h0,0,0), 1'($urandom_range(0,1)), 1'b0);
            for (int i = 0; i < mw; i++) push(mk(0,1,0,0,0,2'd0,2'd0,2'd0,4'h0,0,0), 1'b0, 1'b0);
            push(mk(0,1,0,0,0,2'd0,2'd0,2'd0,4'h0,0,0), 1'b1, 1'b0);
            push(mk(0,0,0,0,1,2'd1,2'd0,2'd0,4'h0,0,1), 1'($urandom_range(0,1)), 1'b0);
         end
         7'b0100011: begin
            push(mk(0,0,0,0,0,2'd0,2'd2,2'd1,4'h0,0,0), 1'($urandom_range(0,1)), 1'b0);
            for (int i = 0; i < mw; i++) push(mk(0,1,1,0,0,2'd0,2'd0,2'd0,4'h0,0,0), 1'b0, 1'b0);
            push(mk(0,1,1,0,0,2'd0,2'd0,2'd0,4'h0,0,1), 1'b1, 1'b0);
         end
         7'b0110011, 7'b0010011: begin
            if (o == 7'b0110011)
               push(mk(0,0,0,0,0,2'd0,2'd2,2'd0,{f7,f3},0,0), 1'($urandom_range(0,1)), 1'b0);
            else
               push(mk(0,0,0,0,0,2'd0,2'd2,2'd1,{(f3 == 3'd5) ? f7 : 1'b0, f3},0,0),
                    1'($urandom_range(0,1)), 1'b0);
            push(mk(0,0,0,0,1,2'd0,2'd0,2'd0,4'h0,0,1), 1'($urandom_range(0,1)), 1'b0);
         end
         7'b1100011:
            push(mk(br_taken(f3, fl),0,0,0,0,2'd0,2'd2,2'd0,4'h8,0,1), 1'($urandom_range(0,1)), 1'b0);
         7'b1101111: begin
            push(mk(1,0,0,0,0,2'd0,2'd1,2'd2,4'h0,0,0), 1'($urandom_range(0,1)), 1'b0);
            push(mk(0,0,0,0,1,2'd0,2'd0,2'd0,4'h0,0,1), 1'($urandom_range(0,1)), 1'b0);
         end
         default:
            push(mk(0,0,0,0,1,2'd3,2'd0,2'd0,4'h0,0,1), 1'($urandom_range(0,1)), 1'b0);
      endcase
   endtask

   task automatic check_now(input exp_t e);
      exp_t obs;
      obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, illegal, retire};
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL ctrl cyc=%0d op=%b f3=%0d observed=%h expected=%h", cyc, op, funct3, obs, e);
      end
      checks++;
      assert (ImmSrc === imm_ref(op)) else begin
         errors++;
         $error("FAIL immsrc cyc=%0d op=%b observed=%b expected=%b", cyc, op, ImmSrc, imm_ref(op));
      end
   endtask

   // Plays n queued cycles; fetch-stall cycles scramble op to show it is ignored there.
   task automatic run_n(input int n, input logic [6:0] cur_op);
      exp_t e;
      for (int k = 0; k < n && q.size() > 0; k++) begin
         e = q.pop_front();
         mem_ready = rdyq.pop_front();
         if (scrq.pop_front()) op = 7'($urandom);
         @(negedge clk);
         check_now(e);
         @(posedge clk);
         #1;
         op = cur_op;
         cyc++;
      end
   endtask

   task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [3:0] fl, input int fw, input int mw);
      op = o; funct3 = f3; funct7 = f7; flags = fl;
      q.delete(); rdyq.delete(); scrq.delete();
      build(o, f3, f7, fl, fw, mw);
      run_n(q.size(), o);
   endtask

   logic [3:0] fls [5];
   logic [6:0] ops [7];

   initial begin
      fls = '{4'b0100, 4'b1000, 4'b1001, 4'b0010, 4'b0000};
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0110111};
      reset = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7 = 1'b0; flags = 4'h0; mem_ready = 1'b1;
      @(negedge clk);
      check_now(mk(0,0,0,0,0,2'd2,2'd0,2'd2,4'h0,0,0));
      @(posedge clk); #1;
      reset = 1'b0;

      do_instr(7'b0110011, 3'd0, 1'b1, 4'h0, 0, 0);
      do_instr(7'b0000011, 3'd2, 1'b0, 4'h0, 0, 2);
      for (int f = 0; f < 8; f++)
         for (int j = 0; j < 5; j++)
            do_instr(7'b1100011, 3'(f), 1'b0, fls[j], 0, 0);
      do_instr(7'b1101111, 3'd0, 1'b0, 4'h0, 0, 0);
      do_instr(7'b1111111, 3'd0, 1'b0, 4'h0, 0, 0);
      do_instr(7'b0010011, 3'd0, 1'b1, 4'h0, 1, 0);

      op = 7'b0100011; funct3 = 3'd2; funct7 = 1'b0;
      q.delete(); rdyq.delete(); scrq.delete();
      build(7'b0100011, 3'd2, 1'b0, 4'h0, 0, 3);
      run_n(4, 7'b0100011);
      mem_ready = 1'b1;
      #1 reset = 1'b1;
      #1 check_now(mk(0,0,0,0,0,2'd2,2'd0,2'd2,4'h0,0,0));
      @(posedge clk); #1;
      check_now(mk(0,0,0,0,0,2'd2,2'd0,2'd2,4'h0,0,0));
      reset = 1'b0;
      do_instr(7'b0110011, 3'd7, 1'b0, 4'h0, 0, 0);

      for (int n = 0; n < 300; n++) begin
         logic [6:0] o;
         int k;
         k = $urandom_range(0, 7);
         if (k == 7) o = 7'($urandom);
         else        o = ops[k];
         do_instr(o, 3'($urandom), 1'($urandom), 4'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
